// File: rtl/fpaddsub_prealign.sv
// fpaddsub_prealign
//   Front end of an IEEE754 single-precision adder/subtractor. It unpacks the
//   operands, orders them by magnitude and right-aligns the smaller mantissa
//   so that a following stage can add or subtract the two mantissas directly.
//   The block is a two-stage valid/ready pipeline:
//     stage 1 : unpack, magnitude compare, swap, special-case flags
//     stage 2 : alignment shift of the smaller mantissa with sticky collection
//
// Ports
//   clk, rst_n            clock; synchronous active-low reset
//   in_valid / in_ready   input handshake for {a, b, op}
//   a, b                  IEEE754 single operands
//   op                    0 = A+B, 1 = A-B
//   out_valid / out_ready output handshake
//   out_ml                larger mantissa  {hidden, frac, 3'b000}
//   out_ms                smaller mantissa aligned right, bit 0 = sticky
//   out_e                 exponent of the larger operand
//   out_s                 result sign
//   out_sub               1 = mantissas must be subtracted
//   out_zero/inf/nan      special-case flags
module fpaddsub_prealign (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        op,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [26:0] out_ml,
   output logic [26:0] out_ms,
   output logic [7:0]  out_e,
   output logic        out_s,
   output logic        out_sub,
   output logic        out_zero,
   output logic        out_inf,
   output logic        out_nan
);

   // ---------------- stage 1 combinational ----------------
   logic [7:0]  ea, eb;
   logic [22:0] fa, fb;
   logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, b_gt, sb_eff;
   logic [30:0] mag_a, mag_b;
   logic [23:0] ma, mb;

   logic [23:0] ml1_d, ms1_d;
   logic [7:0]  e1_d, d1_d;
   logic        s1_d, sub1_d, zero1_d, inf1_d, nan1_d;

   always_comb begin
      ea     = a[30:23];
      eb     = b[30:23];
      fa     = a[22:0];
      fb     = b[22:0];
      a_zero = (ea == 8'd0);
      b_zero = (eb == 8'd0);
      a_inf  = (ea == 8'hFF) && (fa == 23'd0);
      b_inf  = (eb == 8'hFF) && (fb == 23'd0);
      a_nan  = (ea == 8'hFF) && (fa != 23'd0);
      b_nan  = (eb == 8'hFF) && (fb != 23'd0);

      // Denormals are flushed: exponent 0 means a true zero, frac ignored.
      ma     = a_zero ? 24'd0 : {1'b1, fa};
      mb     = b_zero ? 24'd0 : {1'b1, fb};
      mag_a  = {ea, (a_zero ? 23'd0 : fa)};
      mag_b  = {eb, (b_zero ? 23'd0 : fb)};
      // Ties keep A as the larger operand.
      b_gt   = (mag_b > mag_a);

      sb_eff  = b[31] ^ op;
      sub1_d  = a[31] ^ sb_eff;
      s1_d    = b_gt ? sb_eff : a[31];
      ml1_d   = b_gt ? mb : ma;
      ms1_d   = b_gt ? ma : mb;
      e1_d    = b_gt ? eb : ea;
      d1_d    = b_gt ? (eb - ea) : (ea - eb);

      nan1_d  = a_nan | b_nan | (a_inf & b_inf & sub1_d);
      inf1_d  = (a_inf | b_inf) & ~nan1_d;
      zero1_d = a_zero & b_zero;
   end

   // ---------------- pipeline control ----------------
   logic v1_q, v2_q, adv1, adv2;

   assign adv2     = ~v2_q | out_ready;
   assign adv1     = ~v1_q | adv2;
   // Held low while reset is asserted so nothing is accepted then.
   assign in_ready = rst_n & adv1;

   // ---------------- stage 1 registers ----------------
   logic [23:0] ml1_q, ms1_q;
   logic [7:0]  e1_q, d1_q;
   logic        s1_q, sub1_q, zero1_q, inf1_q, nan1_q;

   // ---------------- stage 2 combinational ----------------
   logic [26:0] x_ms, mask, ms2_d;

   always_comb begin
      x_ms  = {ms1_q, 3'b000};
      mask  = 27'd0;
      ms2_d = 27'd0;
      if (d1_q >= 8'd27) begin
         // Everything is shifted out; only the sticky survives.
         ms2_d = {26'd0, |ms1_q};
      end else begin
         // mask selects the bits that fall off the right end.
         mask  = ~(27'h7FF_FFFF << d1_q[4:0]);
         ms2_d = (x_ms >> d1_q[4:0]) | {26'd0, |(x_ms & mask)};
      end
   end

   // ---------------- stage 2 registers ----------------
   logic [26:0] ml2_q, ms2_q;
   logic [7:0]  e2_q;
   logic        s2_q, sub2_q, zero2_q, inf2_q, nan2_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         v1_q    <= 1'b0;
         ml1_q   <= '0;
         ms1_q   <= '0;
         e1_q    <= '0;
         d1_q    <= '0;
         s1_q    <= 1'b0;
         sub1_q  <= 1'b0;
         zero1_q <= 1'b0;
         inf1_q  <= 1'b0;
         nan1_q  <= 1'b0;
         v2_q    <= 1'b0;
         ml2_q   <= '0;
         ms2_q   <= '0;
         e2_q    <= '0;
         s2_q    <= 1'b0;
         sub2_q  <= 1'b0;
         zero2_q <= 1'b0;
         inf2_q  <= 1'b0;
         nan2_q  <= 1'b0;
      end else begin
         if (adv1) v1_q <= in_valid;
         if (adv1 && in_valid) begin
            ml1_q   <= ml1_d;
            ms1_q   <= ms1_d;
            e1_q    <= e1_d;
            d1_q    <= d1_d;
            s1_q    <= s1_d;
            sub1_q  <= sub1_d;
            zero1_q <= zero1_d;
            inf1_q  <= inf1_d;
            nan1_q  <= nan1_d;
         end
         if (adv2) v2_q <= v1_q;
         // Output registers only change when a new item moves in, so they
         // hold while the consumer stalls.
         if (adv2 && v1_q) begin
            ml2_q   <= {ml1_q, 3'b000};
            ms2_q   <= ms2_d;
            e2_q    <= e1_q;
            s2_q    <= s1_q;
            sub2_q  <= sub1_q;
            zero2_q <= zero1_q;
            inf2_q  <= inf1_q;
            nan2_q  <= nan1_q;
         end
      end
   end

   assign out_valid = v2_q;
   assign out_ml    = ml2_q;
   assign out_ms    = ms2_q;
   assign out_e     = e2_q;
   assign out_s     = s2_q;
   assign out_sub   = sub2_q;
   assign out_zero  = zero2_q;
   assign out_inf   = inf2_q;
   assign out_nan   = nan2_q;

endmodule

// File: tb/tb_fpaddsub_prealign.sv
// Directed testbench for fpaddsub_prealign: single vectors with hand-computed
// results, a stalled back-to-back stream, and reset in the middle of traffic.
module tb_fpaddsub_prealign;
   logic        clk = 1'b0;
   logic        rst_n, in_valid, in_ready, op, out_valid, out_ready;
   logic [31:0] a, b;
   logic [26:0] out_ml, out_ms;
   logic [7:0]  out_e;
   logic        out_s, out_sub, out_zero, out_inf, out_nan;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   fpaddsub_prealign dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
      .out_ml(out_ml), .out_ms(out_ms), .out_e(out_e), .out_s(out_s),
      .out_sub(out_sub), .out_zero(out_zero), .out_inf(out_inf), .out_nan(out_nan)
   );

   logic [66:0] obs;
   assign obs = {out_ml, out_ms, out_e, out_s, out_sub, out_zero, out_inf, out_nan};

   // flags = {s, sub, zero, inf, nan}
   function automatic logic [66:0] pk(input logic [26:0] ml, input logic [26:0] ms,
                                      input logic [7:0] e, input logic [4:0] flags);
      return {ml, ms, e, flags};
   endfunction

   task automatic chk(input string tag, input logic [66:0] o, input logic [66:0] e);
      checks++;
      assert (o === e) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, o, e);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One pair through an otherwise empty pipeline with out_ready held 1.
   task automatic run1(input string tag, input logic [31:0] av, input logic [31:0] bv,
                       input logic opv, input logic [66:0] exp);
      a = av; b = bv; op = opv; in_valid = 1'b1;
      #1;
      chk({tag, "_inrdy"}, in_ready, 1);
      step();
      in_valid = 1'b0;
      chk({tag, "_lat1"}, out_valid, 0);
      step();
      chk({tag, "_vld"}, out_valid, 1);
      chk(tag, obs, exp);
      step();
      chk({tag, "_drain"}, out_valid, 0);
   endtask

   logic [31:0] sa [4];
   logic [31:0] sb [4];
   logic [66:0] sexp [4];
   int idx, oidx;
   logic acc, emit;

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; op = 1'b0; a = '0; b = '0;

      // reset state
      step();
      step();
      chk("rst_inrdy", in_ready, 0);
      chk("rst_vld", out_valid, 0);
      chk("rst_out", obs, 0);
      rst_n = 1'b1;
      #1;
      chk("rel_inrdy", in_ready, 1);

      // basic vectors
      run1("add_1p2", 32'h3F800000, 32'h40000000, 1'b0, pk(27'h4000000, 27'h2000000, 8'h80, 5'b00000));
      run1("sub_tie", 32'h3F800000, 32'h3F800000, 1'b1, pk(27'h4000000, 27'h4000000, 8'h7F, 5'b01000));
      run1("d24",     32'h4B800000, 32'h3F800000, 1'b0, pk(27'h4000000, 27'h0000004, 8'h97, 5'b00000));
      run1("d30",     32'h4E800000, 32'h3F800000, 1'b0, pk(27'h4000000, 27'h0000001, 8'h9D, 5'b00000));
      run1("inf_nan", 32'h7F800000, 32'hFF800000, 1'b0, pk(27'h4000000, 27'h4000000, 8'hFF, 5'b01001));
      run1("inf",     32'h7F800000, 32'h3F800000, 1'b0, pk(27'h4000000, 27'h0000001, 8'hFF, 5'b00010));
      run1("zero",    32'h00000000, 32'h80000000, 1'b0, pk(27'h0000000, 27'h0000000, 8'h00, 5'b01100));
      run1("b_big_s", 32'h3F800000, 32'h40000000, 1'b1, pk(27'h4000000, 27'h2000000, 8'h80, 5'b11000));
      run1("sticky",  32'h41800000, 32'h3F800001, 1'b0, pk(27'h4000000, 27'h0400001, 8'h83, 5'b00000));
      run1("denorm",  32'h3F800000, 32'h00000001, 1'b0, pk(27'h4000000, 27'h0000000, 8'h7F, 5'b00000));
      run1("qnan",    32'h7FC00000, 32'h3F800000, 1'b0, pk(27'h6000000, 27'h0000001, 8'hFF, 5'b00001));

      // back-to-back stream with out_ready low for the first 4 cycles
      sa[0] = 32'h3F800000; sb[0] = 32'h40000000; sexp[0] = pk(27'h4000000, 27'h2000000, 8'h80, 5'b00000);
      sa[1] = 32'h4B800000; sb[1] = 32'h3F800000; sexp[1] = pk(27'h4000000, 27'h0000004, 8'h97, 5'b00000);
      sa[2] = 32'h4E800000; sb[2] = 32'h3F800000; sexp[2] = pk(27'h4000000, 27'h0000001, 8'h9D, 5'b00000);
      sa[3] = 32'h41800000; sb[3] = 32'h3F800001; sexp[3] = pk(27'h4000000, 27'h0400001, 8'h83, 5'b00000);
      idx = 0; oidx = 0; op = 1'b0;
      for (int c = 0; c < 30 && oidx < 4; c++) begin
         in_valid  = (idx < 4);
         a         = sa[(idx < 4) ? idx : 0];
         b         = sb[(idx < 4) ? idx : 0];
         out_ready = (c >= 4);
         #1;
         acc  = in_valid & in_ready;
         emit = out_valid & out_ready;
         if (c == 2 || c == 3) begin
            chk("stream_stall_inrdy", in_ready, 0);
            chk("stream_stall_accepts", idx, 2);
            chk("stream_hold_vld", out_valid, 1);
            chk("stream_hold", obs, sexp[0]);
         end
         if (emit) begin
            chk("stream_out", obs, sexp[oidx]);
            oidx++;
         end
         step();
         if (acc) idx++;
      end
      in_valid = 1'b0;
      chk("stream_accepted", idx, 4);
      chk("stream_emitted", oidx, 4);
      chk("stream_nodup", out_valid, 0);
      step();
      chk("stream_nodup2", out_valid, 0);

      // reset with two pairs in flight
      out_ready = 1'b1;
      a = 32'h3F800000; b = 32'h40000000; op = 1'b0; in_valid = 1'b1;
      step();
      a = 32'h4B800000; b = 32'h3F800000;
      step();
      in_valid = 1'b0;
      chk("mid_vld_before", out_valid, 1);
      rst_n = 1'b0;
      step();
      chk("mid_rst_vld", out_valid, 0);
      chk("mid_rst_out", obs, 0);
      chk("mid_rst_inrdy", in_ready, 0);
      rst_n = 1'b1;
      #1;
      chk("mid_rel_inrdy", in_ready, 1);
      for (int c = 0; c < 4; c++) begin
         step();
         chk("mid_no_stale", out_valid, 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/fpaddsub_prealign.md
FPADDSUB_PREALIGN -- requirements
Module: fpaddsub_prealign

Interface
REQ-001 The block SHALL have no parameters; the format is fixed IEEE754 single precision.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 in_valid  input  1  operand pair and op are presented.
REQ-005 in_ready  output  1  block accepts the pair this cycle.
REQ-006 a  input  32  operand A, IEEE754 single.
REQ-007 b  input  32  operand B, IEEE754 single.
REQ-008 op  input  1  0 = A+B, 1 = A-B.
REQ-009 out_valid  output  1  aligned result is presented.
REQ-010 out_ready  input  1  downstream normalize path accepts the result.
REQ-011 out_ml  output  27  larger mantissa {hidden, frac[22:0], 3'b000}.
REQ-012 out_ms  output  27  smaller mantissa aligned right, bit 0 is sticky.
REQ-013 out_e  output  8  exponent of the larger operand.
REQ-014 out_s  output  1  result sign (sign of the larger effective operand).
REQ-015 out_sub  output  1  effective operation, 1 = mantissa subtract.
REQ-016 out_zero, out_inf, out_nan  output  1 each  special-case flags.

Function
REQ-017 Unpack: E==0 SHALL be treated as zero (denormals flushed), hidden bit 0 and frac ignored; else hidden bit 1.
REQ-018 Effective B sign SHALL be b[31]^op; out_sub SHALL be a[31]^b[31]^op.
REQ-019 Magnitude compare SHALL use {E,frac} (31 bits, frac zeroed for E==0); B is "larger" only if strictly greater, ties keep A larger.
REQ-020 out_s SHALL be the sign of the larger operand (effective sign if B).
REQ-021 d = El-Es (8-bit unsigned); out_ms = {Ms,3'b000} >> d with every shifted-out bit ORed into bit 0.
REQ-022 For d >= 27, out_ms SHALL be {26'b0, |Ms}.
REQ-023 out_nan SHALL be 1 if either operand has E==255 and frac!=0, or both are infinite with out_sub==1.
REQ-024 out_inf SHALL be 1 if either operand is infinite and out_nan==0.
REQ-025 out_zero SHALL be 1 if both operands have E==0.
REQ-026 Pipeline: two register stages; stage 1 = unpack/compare/swap/specials, stage 2 = alignment shift and sticky.
REQ-027 Latency SHALL be exactly 2 cycles from accepting handshake (in_valid&in_ready) to out_valid when out_ready is held 1; throughput one pair per cycle.
REQ-028 Stage 2 SHALL advance when it is empty or out_ready==1; stage 1 SHALL advance when it is empty or stage 2 advances; in_ready SHALL equal stage-1 advance.
REQ-029 While out_valid==1 and out_ready==0, all out_* SHALL hold stable.
REQ-030 Results SHALL leave in acceptance order; no loss or duplication under any out_ready pattern.
REQ-031 Simultaneous accept and emit in the same cycle SHALL be supported with a full pipeline.

Reset
REQ-032 While rst_n==0 at a clock edge: both stage-valid bits cleared, all data registers cleared to 0, so out_valid=0 and all out_* = 0 the following cycle.
REQ-033 in_ready SHALL be 0 during reset and 1 in the first cycle after rst_n returns to 1.
REQ-034 Reset mid-operation SHALL discard all in-flight pairs; none emerges after reset.

Verification
REQ-035 a=0x3F800000, b=0x40000000, op=0 -> 2 cycles later out_e=0x80, out_ml=0x4000000, out_ms=0x2000000, out_s=0, out_sub=0, flags 0.
REQ-036 a=b=0x3F800000, op=1 -> out_sub=1, out_ml=out_ms=0x4000000, out_e=0x7F, out_s=0.
REQ-037 a=0x4B800000, b=0x3F800000 (d=24) -> out_ms=0x0000004; a=0x4E800000 (d=30) -> out_ms=0x0000001.
REQ-038 a=0x7F800000, b=0xFF800000, op=0 -> out_nan=1, out_inf=0; a=0x7F800000, b=0x3F800000 -> out_inf=1, out_nan=0.
REQ-039 Stream 4 pairs back-to-back, out_ready=0 for 4 cycles then 1 -> in_ready drops after 2 accepts, outputs hold stable, all 4 emerge in order, once each.
REQ-040 Accept 2 pairs, assert rst_n=0 one cycle -> out_valid=0 and all out_* = 0 next cycle, in_ready=1 after release, no stale result emitted.
